// File: rtl/ahb_lite_mem_slave.sv
// AHB-Lite memory responder: word memory with byte lanes,
// optional wait states and a two-cycle ERROR response.
module ahb_lite_mem_slave #(
   parameter int ADDR_WIDTH  = 12,
   parameter int DATA_WIDTH  = 32,
   parameter int DEPTH       = 256,
   parameter int WAIT_STATES = 0
) (
   input  logic                  HCLK,
   input  logic                  HRESET,
   input  logic                  HSEL,
   input  logic [ADDR_WIDTH-1:0] HADDR,
   input  logic [1:0]            HTRANS,
   input  logic                  HWRITE,
   input  logic [2:0]            HSIZE,
   input  logic [2:0]            HBURST,
   input  logic [DATA_WIDTH-1:0] HWDATA,
   input  logic                  HREADY,
   output logic [DATA_WIDTH-1:0] HRDATA,
   output logic                  HREADYOUT,
   output logic                  HRESP
);
   localparam int IW = $clog2(DEPTH);
   localparam int NB = DATA_WIDTH / 8;

   typedef enum logic [2:0] {
      S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2
   } state_t;

   state_t                state, state_n;
   logic [3:0]            wcnt, wcnt_n;
   logic [IW+1:0]         addr_q;
   logic                  write_q;
   logic [1:0]            size_q;
   logic [DATA_WIDTH-1:0] rdata_q;
   logic [DATA_WIDTH-1:0] rd_word;
   logic [DATA_WIDTH-1:0] mem_word;
   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [NB-1:0]         be;
   logic [IW-1:0]         rd_idx;
   logic                  accept;
   logic                  illegal;
   logic                  commit;
   logic                  fwd;
   logic                  unused_ok;

   assign unused_ok = ^{HBURST, HTRANS[0]};

   assign accept = HSEL && HREADY && HTRANS[1] &&
                   (state == S_IDLE || state == S_DATA ||
                    state == S_ERR2);

   assign illegal = (HSIZE > 3'd2) ||
                    (HSIZE == 3'd1 && HADDR[0]) ||
                    (HSIZE == 3'd2 && HADDR[1:0] != 2'b00) ||
                    (32'(HADDR[ADDR_WIDTH-1:2]) >= 32'(DEPTH));

   assign commit = (state == S_DATA) && HREADY && write_q;

   always_comb begin
      be = '0;
      unique case (size_q)
         2'd0:    be[addr_q[1:0]] = 1'b1;
         2'd1:    be = addr_q[1] ? 4'b1100 : 4'b0011;
         default: be = 4'b1111;
      endcase
   end

   // A read entering DATA straight from an accept may hit the word
   // being written this very edge, so merge the committing lanes.
   assign rd_idx   = (state == S_WAIT) ? addr_q[IW+1:2] : HADDR[IW+1:2];
   assign mem_word = mem[rd_idx];
   assign fwd      = commit && (HADDR[IW+1:2] == addr_q[IW+1:2]);

   always_comb begin
      rd_word = mem_word;
      for (int i = 0; i < NB; i++)
         if (fwd && be[i])
            rd_word[8*i +: 8] = HWDATA[8*i +: 8];
   end

   always_comb begin
      state_n = state;
      wcnt_n  = wcnt;
      unique case (state)
         S_IDLE, S_DATA, S_ERR2: begin
            if (HREADY) begin
               state_n = S_IDLE;
               if (accept) begin
                  if (illegal)
                     state_n = S_ERR1;
                  else if (WAIT_STATES > 0) begin
                     state_n = S_WAIT;
                     wcnt_n  = 4'(WAIT_STATES - 1);
                  end else
                     state_n = S_DATA;
               end
            end
         end
         S_WAIT: begin
            if (wcnt == 4'd0) state_n = S_DATA;
            else              wcnt_n  = wcnt - 4'd1;
         end
         S_ERR1:  state_n = S_ERR2;
         default: state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         state   <= S_IDLE;
         wcnt    <= '0;
         addr_q  <= '0;
         write_q <= 1'b0;
         size_q  <= '0;
         rdata_q <= '0;
      end else begin
         state <= state_n;
         wcnt  <= wcnt_n;
         if (accept) begin
            addr_q  <= HADDR[IW+1:0];
            write_q <= HWRITE;
            size_q  <= HSIZE[1:0];
         end
         if (state_n != S_DATA)
            rdata_q <= '0;
         else if (state != S_DATA || HREADY)
            rdata_q <= rd_word;
      end
   end

   always_ff @(posedge HCLK) begin
      if (commit && !HRESET)
         for (int i = 0; i < NB; i++)
            if (be[i])
               mem[addr_q[IW+1:2]][8*i +: 8] <= HWDATA[8*i +: 8];
   end

   assign HREADYOUT = !(state == S_WAIT || state == S_ERR1);
   assign HRESP     = (state == S_ERR1) || (state == S_ERR2);
   assign HRDATA    = rdata_q;

endmodule

// File: doc/ahb_lite_mem_slave.md
Name: ahb_lite_mem_slave

Overview:
AHB-Lite responder with an internal word-addressed memory. It serves single and burst transfers from any AHB-Lite master and inserts a parameterised number of wait states. It issues the two-cycle ERROR response for illegal transfers. It is the synthesizable slave that the team's AHB driver, monitor and scoreboard environment targets as DUT.

Parameters:
ADDR_WIDTH, 12, HADDR width in bits (byte address).
DATA_WIDTH, 32, HWDATA/HRDATA width; fixed at 32, four byte lanes, little-endian.
DEPTH, 256, number of 32-bit memory words.
WAIT_STATES, 0, HREADYOUT-low cycles inserted per OKAY data phase (0..15).

Ports:
HCLK  in  1  clock, all state updates on rising edge
HRESET  in  1  asynchronous, active-high reset
HSEL  in  1  slave select
HADDR  in  ADDR_WIDTH  byte address
HTRANS  in  2  IDLE=0, BUSY=1, NONSEQ=2, SEQ=3
HWRITE  in  1  1=write, 0=read
HSIZE  in  3  0=byte, 1=half, 2=word; others illegal
HBURST  in  3  accepted, not decoded (burst addresses arrive on HADDR)
HWDATA  in  32  write data, valid in data phase
HREADY  in  1  bus ready (mux of all HREADYOUTs)
HRDATA  out  32  read data
HREADYOUT  out  1  slave ready
HRESP  out  1  0=OKAY, 1=ERROR

Behaviour:
- Reset (asynchronous, any time, including mid-wait or mid-error):
  - State goes to IDLE; HREADYOUT=1, HRESP=0, HRDATA=0.
  - Wait counter and captured address-phase registers are cleared; any pending write is dropped.
  - Memory contents are not cleared.
- Address phase is accepted only when HSEL=1, HREADY=1 and HTRANS[1]=1. On acceptance, capture HADDR, HWRITE and HSIZE.
- HSEL=1, HREADY=1 with HTRANS IDLE or BUSY: the next cycle is an OKAY zero-wait data phase with no memory access.
- Illegal transfer (decided at address phase):
  - HSIZE>2.
  - HSIZE=1 with HADDR[0]=1.
  - HSIZE=2 with HADDR[1:0]!=0.
  - HADDR[ADDR_WIDTH-1:2] >= DEPTH.
- States:
  - IDLE: HREADYOUT=1, HRESP=0. Legal accept goes to WAIT if WAIT_STATES>0, else to DATA. Illegal accept goes to ERR1.
  - WAIT: HREADYOUT=0, HRESP=0. Counter loads WAIT_STATES-1 and decrements. Goes to DATA when it reaches 0, so there are exactly WAIT_STATES low cycles.
  - DATA: HREADYOUT=1, HRESP=0, final data-phase cycle. A write commits at this clock edge. A new accept here is pipelined and follows the same IDLE rules; with no accept, go to IDLE.
  - ERR1: HREADYOUT=0, HRESP=1. Unconditionally goes to ERR2.
  - ERR2: HREADYOUT=1, HRESP=1. A new accept is legal here (master may or may not cancel), same rules; otherwise go to IDLE. Memory is never modified by an errored transfer.
- Writes:
  - Byte enables come from the captured size and address: byte selects lane addr[1:0]; half selects lanes {addr[1],0} and {addr[1],1}; word selects all four lanes.
  - Only the enabled lanes of HWDATA are written, at the DATA-cycle edge.
- Reads:
  - HRDATA carries the full 32-bit word mem[addr>>2] during the DATA cycle. The master picks the lanes.
  - HRDATA=0 in all other states.
  - HRDATA is registered and is loaded on the edge entering DATA.
- Read-after-write hazard: a read address phase accepted in the same cycle as a write DATA cycle to the same word must return the merged data (new lanes from HWDATA, other lanes from memory). Forwarding is mandatory.
- HREADY=0 (another slave stalling) while this slave is in IDLE, DATA or ERR2: no address phase is accepted and the outputs hold their state values.
- HBURST is ignored. Burst addresses wrapping past DEPTH raise an error on the offending beat only.

Test Plan:
- WAIT_STATES=0: write word 0xDEADBEEF to 0x010, then read 0x010 → read data phase HREADYOUT=1, HRDATA=0xDEADBEEF, HRESP=0.
- Byte lanes: word 0x00000000 at 0x020, then byte write HWDATA=0x00AB0000 at 0x022, then half write HWDATA=0x1234xxxx at 0x022 → read 0x020 returns 0x12340000. Repeat with a half write HWDATA=0x00005678 at 0x020 → 0x12345678.
- WAIT_STATES=3: single read → exactly 3 cycles HREADYOUT=0, then 1 cycle HREADYOUT=1 with data. Include an INCR4 write burst to 0x040..0x04C → 16 total cycles, then readback matches.
- Errors:
  - Word access to 0x402 (misaligned) → ERR1 then ERR2.
  - Word access to 0x400 (DEPTH=256, out of range) → ERR1 then ERR2.
  - Each error sequence is HRESP=1/HREADYOUT=0, then HRESP=1/HREADYOUT=1.
  - Memory is unchanged, and the next legal transfer is OKAY.
- Back-to-back: write 0xCAFEF00D to 0x030 immediately followed by a read of 0x030 → the read returns 0xCAFEF00D via forwarding. Then BUSY between SEQ beats → OKAY, no access.
- Assert HRESET during WAIT (WAIT_STATES=5, cycle 2) → same cycle HREADYOUT=1, HRESP=0, HRDATA=0. After release, the pending write is not committed and a new transfer completes normally.
